// File: rtl/chunked_serial_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : chunked_serial_adder_if
// Purpose  : Start/ready request bundle and result bundle for the chunked
//            serial add/subtract unit.
// Revision : 1.0 - initial release
// ============================================================================
interface chunked_serial_adder_if #(
   parameter int WIDTH = 16
) ();

   // Request side
   logic             start_in;
   logic             sub_in;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             c_in;

   // Status and result side
   logic             ready_out;
   logic             busy_out;
   logic [WIDTH-1:0] sum_out;
   logic             c_out;
   logic             ovf_out;
   logic             done_out;

   // Requester: drives operands and start, observes status and result
   modport master (
      output start_in, sub_in, a_in, b_in, c_in,
      input  ready_out, busy_out, sum_out, c_out, ovf_out, done_out
   );

   // Adder: consumes operands and start, produces status and result
   modport slave (
      input  start_in, sub_in, a_in, b_in, c_in,
      output ready_out, busy_out, sum_out, c_out, ovf_out, done_out
   );

endinterface
`default_nettype wire

// File: rtl/chunked_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : chunked_serial_adder
// Purpose  : Multi-cycle add/subtract. WIDTH-bit operands are summed CHUNK
//            bits per clock, LSB chunk first, with a registered carry between
//            chunks. Subtraction is A + ~B + 1 with c_in acting as borrow-in.
// Revision : 1.0 - initial release
// ============================================================================
module chunked_serial_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   chunked_serial_adder_if.slave bus
);

   // Cycles per operation; derived, never overridden
   localparam int NCHUNK   = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
   localparam int CNT_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

   // Reject chunk sizes that do not tile the operand exactly
   generate
      if ((CHUNK < 1) || (CHUNK > WIDTH)) begin : g_chunk_range_err
         $error("chunked_serial_adder: CHUNK must be in 1..WIDTH");
      end else if ((WIDTH % CHUNK) != 0) begin : g_chunk_div_err
         $error("chunked_serial_adder: CHUNK must divide WIDTH");
      end
   endgenerate

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [WIDTH-1:0]    r_a;        // latched operand A
   logic [WIDTH-1:0]    r_b;        // latched effective operand B (inverted for subtract)
   logic                r_carry;    // carry between chunks
   logic [WIDTH-1:0]    r_work;     // partially assembled sum
   logic [WIDTH-1:0]    r_sum;
   logic                r_c;
   logic                r_ovf;
   logic                r_done;

   logic [CHUNK-1:0]    w_a_chunk;
   logic [CHUNK-1:0]    w_b_chunk;
   logic [CHUNK-1:0]    w_chunk_sum;
   logic                w_carry_next;
   logic [WIDTH-1:0]    w_work_next;
   logic                w_ovf;

   // Select the operand chunks addressed by the chunk counter
   always_comb begin
      w_a_chunk = '0;
      w_b_chunk = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         if (r_cnt == CNT_W'(i)) begin
            w_a_chunk = r_a[i*CHUNK +: CHUNK];
            w_b_chunk = r_b[i*CHUNK +: CHUNK];
         end
      end
   end

   // One CHUNK-bit ripple slice; the extra bit is the carry into the next chunk
   assign {w_carry_next, w_chunk_sum} = {1'b0, w_a_chunk}
                                      + {1'b0, w_b_chunk}
                                      + {{CHUNK{1'b0}}, r_carry};

   // Merge the freshly computed chunk into the working sum
   always_comb begin
      w_work_next = r_work;
      for (int i = 0; i < NCHUNK; i++) begin
         if (r_cnt == CNT_W'(i)) begin
            w_work_next[i*CHUNK +: CHUNK] = w_chunk_sum;
         end
      end
   end

   // Signed overflow: like-signed operands producing a result of the other sign
   assign w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_work_next[WIDTH-1] != r_a[WIDTH-1]);

   // Control FSM, datapath registers and registered results
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_work  <= '0;
         r_sum   <= '0;
         r_c     <= 1'b0;
         r_ovf   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start_in) begin
                  r_a     <= bus.a_in;
                  r_b     <= bus.sub_in ? ~bus.b_in : bus.b_in;
                  r_carry <= bus.c_in ^ bus.sub_in;
                  r_cnt   <= '0;
                  r_state <= RUN;
               end
            end
            RUN: begin
               // start_in is deliberately ignored here: no queueing
               r_work  <= w_work_next;
               r_carry <= w_carry_next;
               if (r_cnt == LAST_CNT) begin
                  r_sum   <= w_work_next;
                  r_c     <= w_carry_next;
                  r_ovf   <= w_ovf;
                  r_done  <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.ready_out = (r_state == IDLE);
   assign bus.busy_out  = (r_state == RUN);
   assign bus.sum_out   = r_sum;
   assign bus.c_out     = r_c;
   assign bus.ovf_out   = r_ovf;
   assign bus.done_out  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_chunked_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_chunked_serial_adder
// Purpose  : Directed self-checking bench for chunked_serial_adder, covering
//            CHUNK=4 and CHUNK=16 instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chunked_serial_adder;

   logic clk;
   logic rst;

   int checks;
   int errors;
   logic [15:0] prev_sum;

   chunked_serial_adder_if #(.WIDTH(16)) bus4  ();
   chunked_serial_adder_if #(.WIDTH(16)) bus16 ();

   chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) u_dut4 (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus4)
   );

   chunked_serial_adder #(.WIDTH(16), .CHUNK(16)) u_dut16 (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus16)
   );

   // Free-running clock, 10 time-unit period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case anything stalls
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One operation on the CHUNK=4 instance; optionally pulses start during RUN
   task automatic run4(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input logic cin,
                       input logic [15:0] es, input logic ec, input logic eo,
                       input bit noise);
      int  lat;
      bit  got;
      @(negedge clk);
      bus4.a_in     = a;
      bus4.b_in     = b;
      bus4.sub_in   = sub;
      bus4.c_in     = cin;
      bus4.start_in = 1'b1;
      @(posedge clk);                       // accept edge
      @(negedge clk);
      bus4.start_in = noise;
      bus4.a_in     = ~a;                   // operands change after accept
      bus4.b_in     = 16'hAAAA;
      bus4.sub_in   = ~sub;
      bus4.c_in     = ~cin;
      check({tag, "_busy"}, bus4.busy_out, 1);
      check({tag, "_held"}, bus4.sum_out, prev_sum);
      lat = 0;
      got = 1'b0;
      for (int i = 1; i <= 12 && !got; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (i == 2) bus4.start_in = 1'b0;
         if (bus4.done_out === 1'b1) begin
            got = 1'b1;
            lat = i;
         end else begin
            check({tag, "_rdy_lo"}, bus4.ready_out, 0);
         end
      end
      check({tag, "_lat"}, lat, 4);
      check({tag, "_sum"}, bus4.sum_out, es);
      check({tag, "_c"}, bus4.c_out, ec);
      check({tag, "_ovf"}, bus4.ovf_out, eo);
      check({tag, "_rdy_done"}, bus4.ready_out, 1);
      @(negedge clk);
      check({tag, "_pulse"}, bus4.done_out, 0);
      check({tag, "_keep"}, bus4.sum_out, es);
      prev_sum = es;
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      prev_sum = 16'h0000;
      rst      = 1'b1;
      bus4.start_in  = 1'b0;
      bus4.sub_in    = 1'b0;
      bus4.a_in      = '0;
      bus4.b_in      = '0;
      bus4.c_in      = 1'b0;
      bus16.start_in = 1'b0;
      bus16.sub_in   = 1'b0;
      bus16.a_in     = '0;
      bus16.b_in     = '0;
      bus16.c_in     = 1'b0;

      // Reset state
      @(posedge clk);
      @(negedge clk);
      check("rst_sum",   bus4.sum_out, 0);
      check("rst_done",  bus4.done_out, 0);
      check("rst_busy",  bus4.busy_out, 0);
      check("rst_ready", bus4.ready_out, 1);
      rst = 1'b0;

      // Additions
      run4("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
      run4("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      run4("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);

      // Subtractions
      run4("sub_neg",   16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
      run4("sub_ovf",   16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);

      // Async reset two RUN edges into an operation
      @(negedge clk);
      bus4.a_in     = 16'h0F0F;
      bus4.b_in     = 16'h0101;
      bus4.sub_in   = 1'b0;
      bus4.c_in     = 1'b0;
      bus4.start_in = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus4.start_in = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("arst_sum",   bus4.sum_out, 0);
      check("arst_c",     bus4.c_out, 0);
      check("arst_ovf",   bus4.ovf_out, 0);
      check("arst_busy",  bus4.busy_out, 0);
      check("arst_ready", bus4.ready_out, 1);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("arst_no_done", bus4.done_out, 0);
      end
      prev_sum = 16'h0000;
      run4("post_rst",  16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

      // Borrow-in, then start pulsed during RUN
      run4("sub_borrow", 16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
      run4("ignore",     16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b1);

      // CHUNK=16: back-to-back with start held high
      @(negedge clk);
      bus16.a_in     = 16'h00FF;
      bus16.b_in     = 16'h0001;
      bus16.sub_in   = 1'b0;
      bus16.c_in     = 1'b0;
      bus16.start_in = 1'b1;
      @(posedge clk);                       // accept first
      @(negedge clk);
      check("c16_busy1", bus16.busy_out, 1);
      bus16.a_in = 16'h1000;
      bus16.b_in = 16'h1000;
      @(posedge clk);                       // first completes
      @(negedge clk);
      check("c16_done1",  bus16.done_out, 1);
      check("c16_sum1",   bus16.sum_out, 16'h0100);
      check("c16_rdy1",   bus16.ready_out, 1);
      @(posedge clk);                       // accept second
      @(negedge clk);
      bus16.start_in = 1'b0;
      check("c16_gap",    bus16.done_out, 0);
      check("c16_hold",   bus16.sum_out, 16'h0100);
      @(posedge clk);                       // second completes
      @(negedge clk);
      check("c16_done2",  bus16.done_out, 1);
      check("c16_sum2",   bus16.sum_out, 16'h2000);
      check("c16_c2",     bus16.c_out, 0);
      @(negedge clk);
      check("c16_pulse2", bus16.done_out, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/chunked_serial_adder.md
Name: chunked_serial_adder

Overview:
- Parametrised, multi-cycle add/subtract unit: WIDTH-bit operands processed CHUNK bits per clock, LSB chunk first, with a registered carry between chunks.
- Trades latency for area; successor to the single-bit gate-level adders for wide datapaths.
- Start/ready handshake in, one-cycle done pulse out. Carry-in, carry-out, signed overflow, and an add/subtract mode.

Parameters:
- WIDTH, 16, operand/result width in bits.
- CHUNK, 4, bits added per cycle. Must divide WIDTH; a non-divisor is an elaboration error.
- NCHUNK, derived WIDTH/CHUNK, cycles per operation. Not overridable.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_in  input  1  reset, asynchronous, active-high.
- start_in  input  1  request to begin an operation; accepted only when ready_out=1.
- ready_out  output  1  high when idle and able to accept start_in.
- sub_in  input  1  0: a_in+b_in+c_in; 1: a_in-b_in-c_in (c_in acts as borrow-in).
- a_in  input  WIDTH  operand A, sampled on accept.
- b_in  input  WIDTH  operand B, sampled on accept.
- c_in  input  1  carry/borrow in, sampled on accept.
- sum_out  output  WIDTH  result, registered.
- c_out  output  1  raw carry out of MSB. In subtract mode, 1 = no borrow.
- ovf_out  output  1  signed two's-complement overflow.
- done_out  output  1  one-cycle pulse, result valid.
- busy_out  output  1  high while an operation is in progress.

Behaviour:
- Reset (async, any time, including mid-operation):
  - State returns to IDLE; chunk counter = 0.
  - sum_out=0, c_out=0, ovf_out=0, done_out=0, busy_out=0, ready_out=1.
  - The in-flight operation is discarded with no done pulse.
- FSM has two states, IDLE and RUN.
  - ready_out = (state==IDLE).
  - busy_out = (state==RUN).
- Accept occurs at a rising edge where start_in=1 and state=IDLE. At that edge:
  - Latch a_in.
  - Latch b_eff = sub_in ? ~b_in : b_in.
  - Carry register = c_in ^ sub_in.
  - Chunk counter = 0; go to RUN.
- start_in while in RUN is ignored: no queueing, no error.
- Each RUN edge k (k = 0..NCHUNK-1):
  - Compute {carry, chunk_k} = a[k] + b_eff[k] + carry, where each chunk is CHUNK bits.
  - Store chunk_k into the working sum; increment counter.
- On the edge processing chunk NCHUNK-1:
  - sum_out <= full working sum.
  - c_out <= final carry.
  - ovf_out <= (a_msb == b_eff_msb) && (sum_msb != a_msb).
  - done_out <= 1; state <= IDLE.
- Latency and throughput:
  - Accept at edge E → done_out high in the cycle after edge E+NCHUNK.
  - ready_out is high in that same done cycle, so the next accept can occur at edge E+NCHUNK+1. Throughput is one op per NCHUNK+1 cycles.
- done_out is high for exactly one cycle per completed operation.
- sum_out, c_out and ovf_out hold their values until the next completion. They do not change during a subsequent RUN.
- CHUNK=WIDTH is legal: NCHUNK=1, done one edge after accept.
- Operands may change after accept without affecting the result.

Test Plan:
- WIDTH=16, CHUNK=4, sub=0, c_in=0, 0x1234+0x4321 → sum_out=0x5555, c_out=0, ovf_out=0; done_out pulses exactly 4 edges after the accept edge.
- Add 0xFFFF+0x0001, c_in=0 → 0x0000, c_out=1, ovf=0. Add 0x7FFF+0x0001 → 0x8000, c_out=0, ovf=1.
- Subtract, c_in=0: 0x0005-0x0007 → 0xFFFE, c_out=0, ovf=0. 0x8000-0x0001 → 0x7FFF, c_out=1, ovf=1. 0x0005-0x0003 with c_in=1 → 0x0001, c_out=1.
- Pulse start_in during RUN with different operands → ignored; first result intact; ready_out stays 0 until the done cycle.
- Start, then assert rst_in asynchronously mid-cycle after 2 RUN edges → outputs immediately reset values, no done pulse. After release, a new op 0x0001+0x0001 → 0x0002.
- CHUNK=16 back-to-back: hold start_in=1 with two ops (0x00FF+0x0001, then 0x1000+0x1000) → results 0x0100 then 0x2000, done pulses 2 cycles apart.
